// File: rtl/v_universal_shift_register.sv
// Universal shift register: shift, rotate, arithmetic shift, load and clear,
// plus a saturating count of shifts since the last load.
module v_universal_shift_register #(
    parameter int unsigned        WIDTH = 8,
    parameter logic [WIDTH-1:0]   INIT  = '0
) (
    input  logic                          C,
    input  logic                          CLR,
    input  logic                          CE,
    input  logic [2:0]                    MODE,
    input  logic                          SI,
    input  logic [WIDTH-1:0]              PI,
    output logic [WIDTH-1:0]              PO,
    output logic                          SO,
    output logic [$clog2(WIDTH+1)-1:0]    CNT,
    output logic                          FULL
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_ASR   = 3'b101,
        MODE_LOAD  = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    logic [WIDTH-1:0] r_data;
    logic             r_so;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_data_nxt;
    logic             w_so_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_shift;
    logic             w_reload;

    // Next-state decode; defaults hold everything
    always_comb begin
        w_data_nxt = r_data;
        w_so_nxt   = r_so;
        w_shift    = 1'b0;
        w_reload   = 1'b0;
        case (mode_e'(MODE))
            MODE_HOLD: ;
            MODE_SHL: begin
                w_data_nxt = {r_data[WIDTH-2:0], SI};
                w_so_nxt   = r_data[WIDTH-1];
                w_shift    = 1'b1;
            end
            MODE_SHR: begin
                w_data_nxt = {SI, r_data[WIDTH-1:1]};
                w_so_nxt   = r_data[0];
                w_shift    = 1'b1;
            end
            MODE_ROL: begin
                w_data_nxt = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                w_so_nxt   = r_data[WIDTH-1];
                w_shift    = 1'b1;
            end
            MODE_ROR: begin
                w_data_nxt = {r_data[0], r_data[WIDTH-1:1]};
                w_so_nxt   = r_data[0];
                w_shift    = 1'b1;
            end
            MODE_ASR: begin
                w_data_nxt = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
                w_so_nxt   = r_data[0];
                w_shift    = 1'b1;
            end
            MODE_LOAD: begin
                w_data_nxt = PI;
                w_reload   = 1'b1;
            end
            MODE_CLEAR: begin
                w_data_nxt = INIT;
                w_reload   = 1'b1;
            end
            default: ;
        endcase
    end

    // Shift counter saturates at WIDTH, cleared by load or sync clear
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_reload) begin
            w_cnt_nxt = '0;
        end else if (w_shift && (r_cnt != CNT_W'(WIDTH))) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            r_data <= INIT;
            r_so   <= 1'b0;
            r_cnt  <= '0;
        end else if (CE) begin
            r_data <= w_data_nxt;
            r_so   <= w_so_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign PO   = r_data;
    assign SO   = r_so;
    assign CNT  = r_cnt;
    assign FULL = (r_cnt == CNT_W'(WIDTH));

endmodule

// File: tb/tb_v_universal_shift_register.sv
// Randomized bench for v_universal_shift_register: an 8-bit and a 16-bit
// instance are driven together and compared against a word-level model.
module tb_v_universal_shift_register;

    logic        C;
    logic        CLR;
    logic        CE;
    logic [2:0]  MODE;
    logic        SI;
    logic [15:0] PI;

    logic [7:0]  po8;
    logic        so8;
    logic [3:0]  cnt8;
    logic        full8;
    logic [15:0] po16;
    logic        so16;
    logic [4:0]  cnt16;
    logic        full16;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] m8_r,  m16_r;
    logic        m8_so, m16_so;
    int          m8_cnt, m16_cnt;

    localparam logic [15:0] INIT16 = 16'hA5A5;

    v_universal_shift_register #(.WIDTH(8)) u_dut8 (
        .C(C), .CLR(CLR), .CE(CE), .MODE(MODE), .SI(SI), .PI(PI[7:0]),
        .PO(po8), .SO(so8), .CNT(cnt8), .FULL(full8)
    );

    v_universal_shift_register #(.WIDTH(16), .INIT(INIT16)) u_dut16 (
        .C(C), .CLR(CLR), .CE(CE), .MODE(MODE), .SI(SI), .PI(PI),
        .PO(po16), .SO(so16), .CNT(cnt16), .FULL(full16)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Word-level reference: each mode expressed as arithmetic on a masked integer
    function automatic void ref_step(input int w, input logic [63:0] init, input logic ce,
                                     input logic [2:0] mode, input logic si, input logic [63:0] pi,
                                     inout logic [63:0] r, inout logic so, inout int cnt);
        logic [63:0] mask;
        logic [63:0] top;
        logic        msb, lsb;
        if (!ce) return;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        top  = 64'd1 << (w - 1);
        msb  = r[w-1];
        lsb  = r[0];
        case (mode)
            3'd1: begin so = msb; r = ((r << 1) | 64'(si)) & mask; end
            3'd2: begin so = lsb; r = (r >> 1) | (si ? top : 64'd0); end
            3'd3: begin so = msb; r = ((r << 1) | 64'(msb)) & mask; end
            3'd4: begin so = lsb; r = (r >> 1) | (lsb ? top : 64'd0); end
            3'd5: begin so = lsb; r = (r >> 1) | (msb ? top : 64'd0); end
            3'd6: begin r = pi & mask; cnt = 0; end
            3'd7: begin r = init; cnt = 0; end
            default: ;
        endcase
        if (mode >= 3'd1 && mode <= 3'd5 && cnt < w) cnt++;
    endfunction

    task automatic model_reset();
        m8_r = 64'd0;           m8_so = 1'b0;  m8_cnt = 0;
        m16_r = 64'(INIT16);    m16_so = 1'b0; m16_cnt = 0;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".po8"},    64'(po8),    m8_r);
        check_eq({tag, ".so8"},    64'(so8),    64'(m8_so));
        check_eq({tag, ".cnt8"},   64'(cnt8),   64'(m8_cnt));
        check_eq({tag, ".full8"},  64'(full8),  64'(m8_cnt == 8));
        check_eq({tag, ".po16"},   64'(po16),   m16_r);
        check_eq({tag, ".so16"},   64'(so16),   64'(m16_so));
        check_eq({tag, ".cnt16"},  64'(cnt16),  64'(m16_cnt));
        check_eq({tag, ".full16"}, 64'(full16), 64'(m16_cnt == 16));
    endtask

    // One clock: drive, advance past the edge, step the model, compare
    task automatic do_op(input logic ce, input logic [2:0] mode, input logic si, input logic [15:0] pi);
        CE = ce; MODE = mode; SI = si; PI = pi;
        @(posedge C); #1;
        ref_step(8,  64'd0,          ce, mode, si, 64'(pi), m8_r,  m8_so,  m8_cnt);
        ref_step(16, 64'(INIT16),    ce, mode, si, 64'(pi), m16_r, m16_so, m16_cnt);
        compare_all("op");
    endtask

    // Assert CLR between edges; outputs must reset before the next edge
    task automatic pulse_reset();
        CE = 1'b1; MODE = 3'b001; SI = 1'b1;
        #2 CLR = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge C); #1;
        compare_all("rst_held");
        CLR = 1'b0;
    endtask

    initial begin
        CLR = 1'b1; CE = 1'b0; MODE = 3'b000; SI = 1'b0; PI = '0;
        model_reset();
        #2;
        compare_all("init_rst");
        check_eq("init_po16", 64'(po16), 64'h0000_0000_0000_A5A5);
        @(posedge C); #1;
        CLR = 1'b0;

        // Serial fill
        begin
            logic [7:0] bits;
            bits = 8'b1011_0010;
            for (int i = 7; i >= 0; i--) do_op(1'b1, 3'b001, bits[i], 16'h0);
        end
        check_eq("fill_po", 64'(po8), 64'hB2);
        check_eq("fill_cnt", 64'(cnt8), 64'd8);
        check_eq("fill_full", 64'(full8), 64'd1);
        do_op(1'b1, 3'b001, 1'b1, 16'h0);
        check_eq("ninth_po", 64'(po8), 64'h65);
        check_eq("ninth_so", 64'(so8), 64'd1);
        check_eq("ninth_cnt", 64'(cnt8), 64'd8);

        // Sync clear while full
        do_op(1'b1, 3'b111, 1'b0, 16'h0);
        check_eq("clr_po", 64'(po8), 64'h00);
        check_eq("clr_full", 64'(full8), 64'd0);
        check_eq("clr_so", 64'(so8), 64'd1);
        check_eq("clr_po16", 64'(po16), 64'hA5A5);

        // Load and rotate
        do_op(1'b1, 3'b110, 1'b0, 16'h0081);
        check_eq("ld_po", 64'(po8), 64'h81);
        do_op(1'b1, 3'b011, 1'b0, 16'h0);
        check_eq("rol_po", 64'(po8), 64'h03);
        check_eq("rol_so", 64'(so8), 64'd1);
        check_eq("rol_cnt", 64'(cnt8), 64'd1);
        do_op(1'b1, 3'b100, 1'b0, 16'h0);
        check_eq("ror_po", 64'(po8), 64'h81);
        check_eq("ror_so", 64'(so8), 64'd1);

        // Arithmetic shift
        do_op(1'b1, 3'b110, 1'b0, 16'h0090);
        for (int i = 0; i < 3; i++) do_op(1'b1, 3'b101, 1'b0, 16'h0);
        check_eq("asr_po", 64'(po8), 64'hF2);
        check_eq("asr_so", 64'(so8), 64'd0);

        // Enable low and hold
        do_op(1'b1, 3'b110, 1'b0, 16'h005A);
        for (int i = 0; i < 4; i++) do_op(1'b0, 3'b001, 1'b1, 16'h0);
        for (int i = 0; i < 4; i++) do_op(1'b1, 3'b000, 1'b1, 16'h0);
        check_eq("hold_po", 64'(po8), 64'h5A);
        check_eq("hold_cnt", 64'(cnt8), 64'd0);

        // Reset in the middle of shifting; next edge performs the selected mode
        for (int i = 0; i < 5; i++) do_op(1'b1, 3'b001, 1'b1, 16'h0);
        pulse_reset();
        check_eq("rst_po16", 64'(po16), 64'hA5A5);
        do_op(1'b1, 3'b001, 1'b1, 16'h0);

        // Randomized traffic with occasional mid-sequence resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset();
            end else begin
                do_op(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 16'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
